// File: rtl/an_code_pkg.sv
// Shared AN-code constants and state type for the SEC encoder/decoder pair.
package an_code_pkg;

  localparam int AN_A      = 67;
  localparam int AN_A_W    = 7;
  localparam int AN_DATA_W = 24;
  localparam int AN_CODE_W = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } an_enc_state_t;

endpackage

// File: rtl/an_encoder_24bits.sv
// Sequential shift-add AN-code encoder: out_code = A*X, one bit of A per cycle.
// Optional AN_ERR_INJ_EN adds a single arithmetic-weight error (+/- 2^inj_pos) on the codeword.
module an_encoder_24bits
  import an_code_pkg::*;
#(
  parameter int DATA_W = AN_DATA_W,
  parameter int A      = AN_A,
  parameter int A_W    = AN_A_W,
  parameter int CODE_W = AN_CODE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
`ifdef AN_ERR_INJ_EN
  input  logic              inj_en,
  input  logic              inj_neg,
  input  logic [4:0]        inj_pos,
`endif
  output logic              busy
);

  localparam int             CNT_W  = $clog2(A_W + 1);
  localparam logic [A_W-1:0] A_BITS = A_W'(A);

  an_enc_state_t     state_q, state_d;
  logic [CODE_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] x_reg_q, x_reg_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              vld_q, vld_d;
  logic [CODE_W-1:0] acc_sum;

`ifdef AN_ERR_INJ_EN
  logic              inj_en_q, inj_en_d;
  logic              inj_neg_q, inj_neg_d;
  logic [4:0]        inj_pos_q, inj_pos_d;

  // Positions beyond the codeword width leave the codeword untouched.
  function automatic logic [CODE_W-1:0] inject(input logic [CODE_W-1:0] code,
                                               input logic              en,
                                               input logic              neg,
                                               input logic [4:0]        pos);
    logic [CODE_W-1:0] delta;
    delta = '0;
    if (en && (32'(pos) < CODE_W)) delta = CODE_W'(1) << pos;
    return neg ? (code - delta) : (code + delta);
  endfunction
`endif

  assign acc_sum = A_BITS[cnt_q]
                 ? acc_q + ({{(CODE_W-DATA_W){1'b0}}, x_reg_q} << cnt_q)
                 : acc_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    x_reg_d   = x_reg_q;
    code_d    = code_q;
    vld_d     = vld_q;
`ifdef AN_ERR_INJ_EN
    inj_en_d  = inj_en_q;
    inj_neg_d = inj_neg_q;
    inj_pos_d = inj_pos_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_reg_d   = in_data;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = MUL;
`ifdef AN_ERR_INJ_EN
          inj_en_d  = inj_en;
          inj_neg_d = inj_neg;
          inj_pos_d = inj_pos;
`endif
        end
      end
      MUL: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
        // Last bit of A: the codeword is final on this edge.
        if (cnt_q == CNT_W'(A_W - 1)) begin
          state_d = DONE;
          vld_d   = 1'b1;
`ifdef AN_ERR_INJ_EN
          code_d  = inject(acc_sum, inj_en_q, inj_neg_q, inj_pos_q);
`else
          code_d  = acc_sum;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      x_reg_q   <= '0;
      code_q    <= '0;
      vld_q     <= 1'b0;
`ifdef AN_ERR_INJ_EN
      inj_en_q  <= 1'b0;
      inj_neg_q <= 1'b0;
      inj_pos_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      x_reg_q   <= x_reg_d;
      code_q    <= code_d;
      vld_q     <= vld_d;
`ifdef AN_ERR_INJ_EN
      inj_en_q  <= inj_en_d;
      inj_neg_q <= inj_neg_d;
      inj_pos_q <= inj_pos_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = vld_q;
  assign out_code  = code_q;

endmodule
